change_dispenser: RTL and testbench

Downstream of the purchase controller. Consumes its transaction result (`done`/`end_trans` plus the 8-bit `sum_money` and `price` values) and pays out change or a full refund, one coin at a time, to the coin hopper. Uses a greedy 20/10/5 denomination walk over a valid/ack handshake. Reports completion, failure and any unpaid remainder.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/coin_select.sv | 21 ++
 rtl/change_dispenser.sv | 147 ++++++++++++++
 tb/tb_change_dispenser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending types: coin one-hot encoding, coin values and dispenser states.
// Pure declarations, no logic.
package vend_pkg;

  typedef enum logic [2:0] {
    COIN_NONE = 3'b000,
    COIN_5    = 3'b001,
    COIN_10   = 3'b010,
    COIN_20   = 3'b100
  } coin_t;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  typedef enum logic [2:0] {IDLE, LOAD, SEL, DISP, FIN, ERR} state_t;

  function automatic logic [7:0] coin_value(input logic [2:0] coin);
    case (coin)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      COIN_20: coin_value = VAL_20;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy picker: largest in-stock coin not exceeding the amount; zero latency.
// No handshake; none is set when no coin qualifies.
module coin_select
  import vend_pkg::*;
(
  input  logic [7:0] amount,
  input  logic [2:0] avail,
  output logic [2:0] coin,
  output logic       none
);

  always_comb begin
    coin = COIN_NONE;
    none = 1'b0;
    if (amount >= VAL_20 && avail[2])      coin = COIN_20;
    else if (amount >= VAL_10 && avail[1]) coin = COIN_10;
    else if (amount >= VAL_5 && avail[0])  coin = COIN_5;
    else                                   none = 1'b1;
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays change/refunds one coin at a time over valid/ack; coin_valid 3 cycles after trigger.
// CHANGE_INVENTORY_EN enables per-denomination stock tracking; otherwise supply is unlimited.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int STOCK_W    = 6,
  parameter int STOCK_INIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic       end_trans,
  input  logic [7:0] sum_money,
  input  logic [7:0] price,
  input  logic       coin_ack,
  input  logic       refill,
  output logic [2:0] coin_out,
  output logic       coin_valid,
  output logic       busy,
  output logic       change_done,
  output logic       change_err,
  output logic [7:0] remain,
  output logic [2:0] stock_empty
);

  localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);

  state_t     state, state_nxt;
  logic       trig_q, trig_done_q, ack_q;
  logic [7:0] sum_q, price_q;
  logic [7:0] amount, amount_nxt;
  logic [2:0] coin_q, coin_nxt;
  logic [2:0] avail, pick, dec;
  logic       pick_none;

  coin_select u_sel (
    .amount (amount),
    .avail  (avail),
    .coin   (pick),
    .none   (pick_none)
  );

  // Triggers are captured only in IDLE with nothing pending; ack only while a coin is offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q      <= 1'b0;
      trig_done_q <= 1'b0;
      sum_q       <= '0;
      price_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      trig_q <= (state == IDLE) && !trig_q && (done || end_trans);
      if ((state == IDLE) && !trig_q) begin
        trig_done_q <= done;
        sum_q       <= sum_money;
        price_q     <= price;
      end
      ack_q <= coin_ack && (state == DISP) && !ack_q;
    end
  end

  always_comb begin
    state_nxt  = state;
    amount_nxt = amount;
    coin_nxt   = coin_q;
    dec        = '0;
    case (state)
      IDLE: if (trig_q) state_nxt = LOAD;
      LOAD: begin
        if (trig_done_q && (price_q > sum_q)) begin
          amount_nxt = '0;
          state_nxt  = ERR;
        end else begin
          amount_nxt = trig_done_q ? (sum_q - price_q) : sum_q;
          state_nxt  = SEL;
        end
      end
      SEL: begin
        if (amount == '0)   state_nxt = FIN;
        else if (pick_none) state_nxt = ERR;
        else begin
          coin_nxt  = pick;
          state_nxt = DISP;
        end
      end
      DISP: if (ack_q) begin
        amount_nxt = amount - coin_value(coin_q);
        dec        = coin_q;
        state_nxt  = SEL;
      end
      FIN, ERR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      amount      <= '0;
      coin_q      <= '0;
      coin_out    <= '0;
      coin_valid  <= 1'b0;
      busy        <= 1'b0;
      change_done <= 1'b0;
      change_err  <= 1'b0;
      remain      <= '0;
    end else begin
      state       <= state_nxt;
      amount      <= amount_nxt;
      coin_q      <= coin_nxt;
      coin_valid  <= (state_nxt == DISP);
      coin_out    <= (state_nxt == DISP) ? coin_nxt : 3'b000;
      busy        <= (state_nxt != IDLE);
      change_done <= (state_nxt == FIN);
      change_err  <= (state_nxt == ERR);
      if (state_nxt == LOAD || state_nxt == FIN) remain <= '0;
      else if (state_nxt == ERR)                 remain <= amount_nxt;
    end
  end

`ifdef CHANGE_INVENTORY_EN
  logic [STOCK_W-1:0] stock [3];

  // A decrement on the same edge as refill wins for its own denomination.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset)       stock[i] <= INIT_V;
      else if (dec[i]) stock[i] <= stock[i] - STOCK_W'(1);
      else if (refill) stock[i] <= INIT_V;
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < 3; i++) avail[i] = |stock[i];
  end

  assign stock_empty = ~avail;
`else
  logic unused_cfg;

  assign avail       = 3'b111;
  assign stock_empty = 3'b000;
  assign unused_cfg  = ^{refill, INIT_V, dec};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, hand sequences, random vs greedy model.
// Builds with or without CHANGE_INVENTORY_EN.
module tb_change_dispenser;

`ifdef CHANGE_INVENTORY_EN
  localparam int INIT  = 1;
  localparam bit UNLIM = 1'b0;
`else
  localparam int INIT  = 8;
  localparam bit UNLIM = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset, done, end_trans, coin_ack, refill;
  logic [7:0] sum_money, price;
  logic [2:0] coin_out, stock_empty;
  logic       coin_valid, busy, change_done, change_err;
  logic [7:0] remain;

  always #5 clk = ~clk;

  change_dispenser #(.STOCK_W(6), .STOCK_INIT(INIT)) dut (
    .clk(clk), .reset(reset), .done(done), .end_trans(end_trans),
    .sum_money(sum_money), .price(price), .coin_ack(coin_ack), .refill(refill),
    .coin_out(coin_out), .coin_valid(coin_valid), .busy(busy),
    .change_done(change_done), .change_err(change_err), .remain(remain),
    .stock_empty(stock_empty)
  );

  typedef struct {
    bit d, e;
    int s, p, hold;
    bit inj;
    int nc, c0, c1, c2;
    bit err;
    int rem, lat;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  int got_q[$], exp_q[$];
  int got_lat, got_rem, exp_rem;
  bit got_ok, got_err, exp_err;
  int tb_stk[3];                  // index 0 = 20, 1 = 10, 2 = 5
  vec_t tbl[8];

  function automatic int coin_val(input logic [2:0] c);
    case (c)
      3'b001:  return 5;
      3'b010:  return 10;
      3'b100:  return 20;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_empty();
    if (UNLIM) return 0;
    return {29'd0, tb_stk[0] == 0, tb_stk[1] == 0, tb_stk[2] == 0};
  endfunction

  // Greedy payout computed directly from the denomination values and remaining stock.
  task automatic model_pay(input bit d, input int s, input int p);
    int vals[3];
    int amt;
    bit found;
    vals = '{20, 10, 5};
    exp_q.delete();
    if (d && p > s) begin
      exp_err = 1'b1;
      exp_rem = 0;
      return;
    end
    amt = d ? s - p : s;
    while (amt > 0) begin
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!found && vals[k] <= amt && (UNLIM || tb_stk[k] > 0)) begin
          exp_q.push_back(vals[k]);
          amt -= vals[k];
          if (!UNLIM) tb_stk[k]--;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
    exp_err = (amt != 0);
    exp_rem = amt;
  endtask

  task automatic do_refill();
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    for (int k = 0; k < 3; k++) tb_stk[k] = INIT;
  endtask

  task automatic run_txn(input bit d, input bit e, input int s, input int p,
                         input int hold, input bit inj);
    int t;
    bit tmo;
    got_q.delete();
    got_ok = 0; got_err = 0; got_rem = -1; got_lat = -1; tmo = 1'b1; t = 0;
    @(negedge clk);
    done = d; end_trans = e; sum_money = 8'(s); price = 8'(p);
    @(negedge clk);
    done = 1'b0; end_trans = 1'b0;
    while (t < 300) begin
      if (coin_valid) begin
        int cv;
        cv = coin_val(coin_out);
        if (got_lat < 0) got_lat = t;
        got_q.push_back(cv);
        for (int h = 0; h < hold; h++) begin
          done = (inj && h == 1);
          if (inj && h == 1) begin sum_money = 8'd99; price = 8'd0; end
          @(negedge clk); t++;
          chk("hold_valid", coin_valid, 1);
          chk("hold_coin", coin_val(coin_out), cv);
        end
        done = 1'b0;
        coin_ack = 1'b1;
        @(negedge clk); coin_ack = 1'b0;
        @(negedge clk);
        chk("gap_valid", coin_valid, 0);
        @(negedge clk); t += 3;
      end else if (change_done || change_err) begin
        got_ok = change_done; got_err = change_err; got_rem = remain;
        if (got_lat < 0) got_lat = t;
        tmo = 1'b0;
        break;
      end else begin
        @(negedge clk); t++;
      end
    end
    if (tmo) begin
      chk("timeout", 1, 0);
    end else begin
      chk("busy_at_pulse", busy, 1);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("pulse_one_cycle", change_done | change_err, 0);
    end
  endtask

  task automatic cmp_txn(input string nm, input int lat);
    chk({nm, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, "_coin"}, got_q[i], exp_q[i]);
    chk({nm, "_err"}, got_err, exp_err);
    chk({nm, "_done"}, got_ok, !exp_err);
    chk({nm, "_remain"}, got_rem, exp_rem);
    if (lat >= 0) chk({nm, "_latency"}, got_lat, lat);
    chk({nm, "_stock_empty"}, stock_empty, exp_empty());
  endtask

  task automatic set_exp(input vec_t v);
    exp_q.delete();
    if (v.nc > 0) exp_q.push_back(v.c0);
    if (v.nc > 1) exp_q.push_back(v.c1);
    if (v.nc > 2) exp_q.push_back(v.c2);
    exp_err = v.err;
    exp_rem = v.rem;
  endtask

  initial begin
    //          d  e   s    p  hold inj nc  c0  c1  c2 err rem lat
    tbl[0] = '{1, 0,  35,  10,  5,  1,  2, 20,  5,  0, 0,  0,  3};
`ifdef CHANGE_INVENTORY_EN
    tbl[1] = '{0, 1,  40,   0,  0,  0,  3, 20, 10,  5, 1,  5,  3};
`else
    tbl[1] = '{0, 1,  40,   0,  0,  0,  2, 20, 20,  0, 0,  0,  3};
`endif
    tbl[2] = '{1, 0,  10,  15,  0,  0,  0,  0,  0,  0, 1,  0,  2};
    tbl[3] = '{1, 0,  30,  30,  0,  0,  0,  0,  0,  0, 0,  0,  3};
    tbl[4] = '{1, 1,  50,  20,  0,  0,  2, 20, 10,  0, 0,  0,  3};
    tbl[5] = '{0, 1,   0,   0,  0,  0,  0,  0,  0,  0, 0,  0,  3};
    tbl[6] = '{1, 0,  20,  17,  0,  0,  0,  0,  0,  0, 1,  3,  3};
    tbl[7] = '{0, 1,  15,   0,  1,  0,  2, 10,  5,  0, 0,  0,  3};

    reset = 1'b1; done = 1'b0; end_trans = 1'b0; coin_ack = 1'b0; refill = 1'b0;
    sum_money = '0; price = '0;
    for (int k = 0; k < 3; k++) tb_stk[k] = INIT;
    repeat (2) @(negedge clk);
    chk("rst_coin_out", coin_out, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_change_done", change_done, 0);
    chk("rst_change_err", change_err, 0);
    chk("rst_remain", remain, 0);
    chk("rst_stock_empty", stock_empty, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      do_refill();
      set_exp(tbl[i]);
      for (int k = 0; k < 3; k++) if (!UNLIM)
        for (int j = 0; j < exp_q.size(); j++)
          if (exp_q[j] == (k == 0 ? 20 : k == 1 ? 10 : 5)) tb_stk[k]--;
      run_txn(tbl[i].d, tbl[i].e, tbl[i].s, tbl[i].p, tbl[i].hold, tbl[i].inj);
      cmp_txn($sformatf("vec%0d", i), tbl[i].lat);
    end

    // Refund of 45: with one coin of each it runs dry after 20/10/5.
    do_refill();
    run_txn(1'b0, 1'b1, 45, 0, 0, 1'b0);
    exp_q.delete();
`ifdef CHANGE_INVENTORY_EN
    exp_q.push_back(20); exp_q.push_back(10); exp_q.push_back(5);
    exp_err = 1'b1; exp_rem = 10;
    for (int k = 0; k < 3; k++) tb_stk[k] = 0;
    chk("r45_stock_empty_all", stock_empty, 3'b111);
`else
    exp_q.push_back(20); exp_q.push_back(20); exp_q.push_back(5);
    exp_err = 1'b0; exp_rem = 0;
`endif
    cmp_txn("refund45", 3);

    // Reset while a coin is being offered.
    do_refill();
    @(negedge clk); end_trans = 1'b1; sum_money = 8'd40;
    @(negedge clk); end_trans = 1'b0;
    for (int i = 0; i < 10 && !coin_valid; i++) @(negedge clk);
    chk("rst_reach_disp", coin_valid, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) tb_stk[k] = INIT;
    chk("disp_rst_coin_valid", coin_valid, 0);
    chk("disp_rst_coin_out", coin_out, 0);
    chk("disp_rst_busy", busy, 0);
    chk("disp_rst_done", change_done, 0);
    chk("disp_rst_err", change_err, 0);
    chk("disp_rst_remain", remain, 0);
    chk("disp_rst_stock_empty", stock_empty, 0);
    set_exp(tbl[1]);
    model_pay(1'b0, 40, 0);
    run_txn(1'b0, 1'b1, 40, 0, 0, 1'b0);
    cmp_txn("after_reset", 3);

    for (int n = 0; n < 40; n++) begin
      bit d, e;
      int s, p;
      if (!UNLIM && ($urandom % 2 == 0)) do_refill();
      d = 1'($urandom % 2);
      e = d ? 1'($urandom % 2) : 1'b1;
      s = ($urandom % 5 == 0) ? int'($urandom_range(0, 120)) : 5 * int'($urandom_range(0, 24));
      p = 5 * int'($urandom_range(0, 20));
      model_pay(d, s, p);
      run_txn(d, e, s, p, int'($urandom_range(0, 2)), 1'b0);
      cmp_txn($sformatf("rand%0d", n), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
